// File: rtl/node_traffic_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : node_traffic_gen_pkg
//  Purpose  : Shared types and constants for the per-node traffic endpoint:
//             packet format, FSM state type, LFSR seed/taps and helpers.
//             `NODES sets the mesh size (defaults to 16 when not supplied).
//  Revision : 1.0  initial release
// ============================================================================
`ifndef NODES
`define NODES 16
`endif

package node_traffic_gen_pkg;

    localparam int unsigned c_nodes  = `NODES;
    localparam int unsigned c_node_w = $clog2(c_nodes);
    localparam int unsigned c_ts_w   = 16;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1 in right-shift form: the new
    // MSB is the XOR of bits 0, 2, 3 and 5.
    localparam logic [15:0] c_lfsr_seed     = 16'hACE1;
    localparam logic [15:0] c_lfsr_tap_mask = 16'h002D;

    typedef struct packed {
        logic [c_node_w-1:0] source;
        logic [c_node_w-1:0] dest;
        logic [c_ts_w-1:0]   timestamp;
    } packet_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } tg_state_t;

    // One LFSR step.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & c_lfsr_tap_mask), s[15:1]};
    endfunction

    // Destination from the LFSR value; never targets the local node.
    function automatic logic [c_node_w-1:0] pick_dest(input logic [15:0] lfsr,
                                                      input int unsigned node_id);
        int unsigned d;
        d = {16'd0, lfsr} % c_nodes;
        if (d == node_id) d = (d + 32'd1) % c_nodes;
        return d[c_node_w-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/node_traffic_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : node_traffic_gen_if
//  Purpose  : Local-port link between a traffic endpoint and the network.
//             master = traffic endpoint, slave = network local port.
//  Revision : 1.0  initial release
// ============================================================================
interface node_traffic_gen_if
    import node_traffic_gen_pkg::*;
();
    packet_t o_data;       // injected packet (endpoint -> network)
    logic    o_data_val;
    logic    i_en;         // network ready to take o_data
    packet_t i_data;       // ejected packet (network -> endpoint)
    logic    i_data_val;

    modport master (
        output o_data, o_data_val,
        input  i_en, i_data, i_data_val
    );

    modport slave (
        input  o_data, o_data_val,
        output i_en, i_data, i_data_val
    );
endinterface

`default_nettype wire

// File: rtl/node_traffic_gen_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tg_fifo
//  Purpose  : Synchronous packet FIFO with full/empty flags. A push while
//             full is accepted only when a pop happens in the same cycle.
//             The head output reads zero while the FIFO is empty.
//  Revision : 1.0  initial release
// ============================================================================
module tg_fifo
    import node_traffic_gen_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic    clk,
    input  wire logic    reset_n,
    input  wire logic    i_push,
    input  wire packet_t i_push_data,
    input  wire logic    i_pop,
    output packet_t      o_head,
    output logic         o_empty,
    output logic         o_full
);

    localparam int c_aw = $clog2(DEPTH);
    localparam logic [c_aw:0] c_full_cnt = (c_aw + 1)'(DEPTH);

    packet_t         r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_full_cnt);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage write; contents need no reset since the head is gated by empty.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/node_traffic_gen.sv
`default_nettype none
// ============================================================================
//  Module   : node_traffic_gen
//  Purpose  : Per-node traffic endpoint. Generates LFSR-addressed packets at a
//             programmable interval, queues and injects them into the local
//             network port, and sinks/counts/checks ejected packets.
//             Optional macro TG_LATENCY_STATS_EN adds latency sum/max outputs.
//  Revision : 1.0  initial release
// ============================================================================
module node_traffic_gen
    import node_traffic_gen_pkg::*;
#(
    parameter int unsigned NODE_ID    = 0,
    parameter int          FIFO_DEPTH = 4,
    parameter int          CNT_W      = 16
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             i_start,
    input  wire logic [7:0]       i_rate,
    input  wire logic [CNT_W-1:0] i_pkt_limit,
    input  wire logic             i_stop,
    node_traffic_gen_if.master    bus,
    output logic [CNT_W-1:0]      o_sent_count,
    output logic [CNT_W-1:0]      o_recv_count,
    output logic [CNT_W-1:0]      o_drop_count,
    output logic                  o_misroute,
    output logic                  o_done
`ifdef TG_LATENCY_STATS_EN
    ,
    output logic [31:0]           o_lat_sum,
    output logic [CNT_W-1:0]      o_lat_max
`endif
);

    tg_state_t        r_state;
    logic [CNT_W-1:0] r_ts;
    logic [CNT_W-1:0] r_gen_cnt;
    logic [CNT_W-1:0] r_sent;
    logic [CNT_W-1:0] r_recv;
    logic [CNT_W-1:0] r_drop;
    logic [7:0]       r_rate_cnt;
    logic [15:0]      r_lfsr;
    logic             r_done;
    logic             r_misroute;

    logic             w_limit_hit;
    logic             w_run_end;
    logic             w_gen_event;
    logic [7:0]       w_rate_reload;
    logic [15:0]      w_lfsr_next;
    packet_t          w_gen_pkt;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    logic             w_xfer;
    logic             w_drop;
    logic             w_unused_rx;

    assign w_limit_hit   = (i_pkt_limit != '0) && (r_gen_cnt == i_pkt_limit);
    assign w_run_end     = i_stop || w_limit_hit;
    assign w_gen_event   = (r_state == ST_RUN) && !w_run_end && (r_rate_cnt == 8'd0);
    assign w_rate_reload = (i_rate == 8'd0) ? 8'd0 : (i_rate - 8'd1);
    assign w_lfsr_next   = lfsr_step(r_lfsr);

    // Injection handshake: valid comes straight from FIFO state, never from i_en.
    assign bus.o_data_val = ~w_fifo_empty;
    assign w_xfer         = ~w_fifo_empty && bus.i_en;
    assign w_drop         = w_gen_event && w_fifo_full && !w_xfer;

    assign w_unused_rx = ^{bus.i_data.source, bus.i_data.timestamp};

    // Assemble the packet produced by a generation event.
    always_comb begin
        w_gen_pkt           = '0;
        w_gen_pkt.source    = c_node_w'(NODE_ID);
        w_gen_pkt.dest      = pick_dest(w_lfsr_next, NODE_ID);
        w_gen_pkt.timestamp = c_ts_w'(r_ts);
    end

    tg_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_gen_event),
        .i_push_data (w_gen_pkt),
        .i_pop       (w_xfer),
        .o_head      (bus.o_data),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full)
    );

    // Free-running timestamp, wraps naturally.
    always_ff @(posedge clk) begin
        if (!reset_n) r_ts <= '0;
        else          r_ts <= r_ts + 1'b1;
    end

    // Control FSM with generation pacing, LFSR stepping and generated count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_gen_cnt  <= '0;
            r_rate_cnt <= '0;
            r_lfsr     <= c_lfsr_seed ^ 16'(NODE_ID);
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_state    <= ST_RUN;
                        r_gen_cnt  <= '0;
                        r_rate_cnt <= '0;
                        r_done     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_run_end) begin
                        r_state <= ST_DRAIN;
                    end else if (r_rate_cnt == 8'd0) begin
                        r_rate_cnt <= w_rate_reload;
                        r_lfsr     <= w_lfsr_next;
                        if (r_gen_cnt != '1) r_gen_cnt <= r_gen_cnt + 1'b1;
                    end else begin
                        r_rate_cnt <= r_rate_cnt - 8'd1;
                    end
                end
                ST_DRAIN: begin
                    // Empty FIFO means the last transfer has already completed.
                    if (w_fifo_empty) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Saturating injection-side counters: accepted and dropped packets.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sent <= '0;
            r_drop <= '0;
        end else begin
            if (w_xfer && (r_sent != '1)) r_sent <= r_sent + 1'b1;
            if (w_drop && (r_drop != '1)) r_drop <= r_drop + 1'b1;
        end
    end

    // Ejection side: count every delivered packet, latch any misroute.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_recv     <= '0;
            r_misroute <= 1'b0;
        end else if (bus.i_data_val) begin
            if (r_recv != '1) r_recv <= r_recv + 1'b1;
            if (bus.i_data.dest != c_node_w'(NODE_ID)) r_misroute <= 1'b1;
        end
    end

    assign o_sent_count = r_sent;
    assign o_recv_count = r_recv;
    assign o_drop_count = r_drop;
    assign o_misroute   = r_misroute;
    assign o_done       = r_done;

`ifdef TG_LATENCY_STATS_EN
    logic [31:0]      r_lat_sum;
    logic [CNT_W-1:0] r_lat_max;
    logic [CNT_W-1:0] w_lat;
    logic [32:0]      w_lat_sum_ext;

    assign w_lat         = r_ts - CNT_W'(bus.i_data.timestamp);
    assign w_lat_sum_ext = {1'b0, r_lat_sum} + 33'(w_lat);

    // Latency accumulation (saturating sum) and running maximum.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_lat_sum <= '0;
            r_lat_max <= '0;
        end else if (bus.i_data_val) begin
            r_lat_sum <= w_lat_sum_ext[32] ? 32'hFFFF_FFFF : w_lat_sum_ext[31:0];
            if (w_lat > r_lat_max) r_lat_max <= w_lat;
        end
    end

    assign o_lat_sum = r_lat_sum;
    assign o_lat_max = r_lat_max;
`endif

endmodule

`default_nettype wire
